// File: rtl/signature_streamer.sv
// Serial signature ROM sequencer: reloads the shifter, packs its
// MSB-first bit stream into bytes and hands them out over valid/ready.
module signature_streamer #(
  parameter int SIG_BITS = 320
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic       sig_q,
  output logic       sig_ld,
  output logic       sig_en,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
);

  localparam int NBYTES = SIG_BITS / 8;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    SEND
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q;
  logic [CW-1:0] byte_cnt_q;
  logic [7:0]    shreg_q;
  logic [7:0]    tx_data_q;
  logic          sig_ld_q;
  logic          sig_en_q;
  logic          tx_valid_q;
  logic          busy_q;
  logic          done_q;

  logic hs;
  logic last_hs;

  // Handshake completes only when abort is not overriding it.
  assign hs      = (state_q == SEND) && tx_ready && !abort;
  assign last_hs = hs && (byte_cnt_q == LAST);

  // Next-state selection; abort wins over any progress.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start && !abort) state_d = LOAD;
      LOAD:  state_d = abort ? IDLE : SHIFT;
      SHIFT: begin
        if (abort)                state_d = IDLE;
        else if (bit_cnt_q == 3'd7) state_d = SEND;
      end
      SEND: begin
        if (abort)        state_d = IDLE;
        else if (last_hs) state_d = IDLE;
        else if (hs)      state_d = SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and Moore outputs registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shreg_q    <= '0;
      tx_data_q  <= '0;
      sig_ld_q   <= 1'b0;
      sig_en_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sig_ld_q   <= (state_d == LOAD);
      sig_en_q   <= (state_d == SHIFT);
      tx_valid_q <= (state_d == SEND);
      busy_q     <= (state_d != IDLE);
      done_q     <= last_hs;
      unique case (state_q)
        IDLE: begin
          bit_cnt_q  <= '0;
          byte_cnt_q <= '0;
        end
        SHIFT: begin
          shreg_q   <= {shreg_q[6:0], sig_q};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7)
            tx_data_q <= {shreg_q[6:0], sig_q};
        end
        SEND: begin
          if (hs && !last_hs)
            byte_cnt_q <= byte_cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign sig_ld   = sig_ld_q;
  assign sig_en   = sig_en_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/signature_streamer.md
# signature_streamer

Sequencer that drives the serial signature ROM shifter and packs its bit stream into bytes for a byte-wide transmit sink.
- On a start request it reloads the shifter and clocks out all SIG_BITS bits MSB-first.
- It assembles each group of 8 bits into a byte and presents each byte on a valid/ready interface, pausing the shifter under backpressure.
- It sits between the signature shifter (ld/en/q) and the chip's byte output path (e.g. UART TX).

## Interface
- SIG_BITS, 320, signature length in bits; must be a nonzero multiple of 8.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request one full signature transfer; sampled only in IDLE.
- abort  input  1  terminate the current transfer; sampled in every non-IDLE state.
- sig_q  input  1  current serial bit from the signature shifter.
- sig_ld  output  1  reload pulse to the shifter (shifter points at bit SIG_BITS-1 on the next cycle).
- sig_en  output  1  advance the shifter by one bit.
- tx_data  output  8  assembled byte; first-received bit in tx_data[7].
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  sink accepts the byte.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last byte is accepted.

## Operation
- States: IDLE, LOAD, SHIFT, SEND. The FSM is Moore:
  - sig_ld = (state==LOAD)
  - sig_en = (state==SHIFT)
  - tx_valid = (state==SEND)
  - busy = (state!=IDLE)
- IDLE:
  - If start=1 and abort=0, go to LOAD.
  - Clear bit_cnt (3 bits) and byte_cnt (width clog2(SIG_BITS/8)).
- LOAD: one cycle, then go to SHIFT.
- SHIFT:
  - Every cycle, shreg <= {shreg[6:0], sig_q}, with sig_en=1 so the shifter advances.
  - When bit_cnt==7: tx_data <= {shreg[6:0], sig_q}, bit_cnt wraps to 0, go to SEND.
- SEND:
  - Hold tx_data and sig_en=0 until tx_valid&&tx_ready at a clock edge.
  - On the handshake, if byte_cnt==SIG_BITS/8-1, go to IDLE and pulse done.
  - Otherwise increment byte_cnt and go to SHIFT.
- Abort:
  - In LOAD, SHIFT or SEND, abort=1 forces IDLE at the next edge.
  - Abort has priority over a same-cycle handshake. No done pulse; the partial byte is discarded.
  - A SEND byte dropped by abort without a handshake is permitted.
- start while busy=1 is ignored (no queuing).
- start and abort both high in IDLE: remain in IDLE.
- The shifter position after abort is irrelevant; every transfer begins with LOAD.
- Reset (async, reset_n=0):
  - State goes to IDLE immediately.
  - shreg, tx_data, counters and all outputs go to 0.
  - This applies mid-transfer too; the partial transfer is lost.

## Timing
- Let E0 be the edge at which start is sampled in IDLE.
  - LOAD occupies cycle E0–E1.
  - SHIFT occupies E1–E9.
  - tx_valid first rises after E9, 9 cycles after E0.
- Byte k (0-based) with tx_ready held high is accepted at edge E0+10+9k. Each byte costs 8 SHIFT cycles + ≥1 SEND cycle.
- For SIG_BITS=320 with tx_ready=1:
  - Last byte accepted at E0+361.
  - done high during cycle E0+361–E0+362.
  - busy falls with the same edge.
- Backpressure of N cycles on a byte delays all later bytes by exactly N cycles. The shifter does not advance while waiting.
- The first sampled bit is the shifter's bit SIG_BITS-1, valid in the cycle after sig_ld.
- New start accepted from the cycle done is high; back-to-back transfers allowed.

## Test plan
- Reset: assert reset_n=0 mid-SEND, asynchronously between edges. Required: busy, tx_valid, sig_en, sig_ld, done, tx_data all 0 before the next edge; FSM in IDLE.
- Full transfer with real shifter, tx_ready=1:
  - Start at E0 gives bytes 0x4C,0x75,0x6B,0x65 ("Luke") through "...2023/03/24.", 0x0D, 0x0A — 40 bytes.
  - First tx_valid at E0+9; done pulse at E0+361; exactly 40 handshakes.
- Backpressure: hold tx_ready=0 for 5 cycles on byte 0.
  - tx_data stays 0x4C and sig_en stays 0 throughout.
  - Byte 1 = 0x75 is accepted at E0+24.
  - done is at E0+366.
- Abort: assert abort in SHIFT of byte 3 (bit_cnt=4).
  - IDLE and busy=0 on the next edge; no done.
  - A following start yields first byte 0x4C again.
- Request handling:
  - start pulsed during SHIFT/SEND has no effect; byte sequence and done timing are unchanged.
  - start=abort=1 in IDLE keeps busy=0 and sig_ld=0.
- Back-to-back: assert start in the done cycle. Required: sig_ld the next cycle; the second transfer repeats identical 40 bytes.
